apb_cmd_issuer: RTL and testbench
=================================

# apb_cmd_issuer

Command front-end that sits directly upstream of `apb_master_slave`. It accepts read/write commands over a valid/ready interface and buffers them in a small FIFO. It presents each command on the master's `apb_addr`/`apb_wdata`/`apb_wr_rd` inputs for a fixed hold window, then captures `apb_rdata`/`apb_slverr` into a one-cycle response. It replaces hand-paced stimulus with a reusable, back-pressured issue stage.

## Interface
Parameters:
- ADDR_WIDTH, 10, width of command/APB address
- DATA_WIDTH, 32, width of write/read data
- DEPTH, 4, command FIFO entries (power of two, ≥2)
- HOLD_CYCLES, 3, cycles each command is held on the master inputs (≥1)

Ports:
- apb_clk  in  1  single clock, all logic on rising edge
- apb_resetn  in  1  reset, asynchronous and active-low
- cmd_valid  in  1  command offered
- cmd_ready  out  1  FIFO can accept (= not full)
- cmd_wr_rd  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_WIDTH  target address
- cmd_wdata  in  DATA_WIDTH  write data (ignored for reads)
- apb_addr  out  ADDR_WIDTH  to master
- apb_wdata  out  DATA_WIDTH  to master
- apb_wr_rd  out  1  to master
- apb_rdata  in  DATA_WIDTH  from master
- apb_slverr  in  1  from master
- rsp_valid  out  1  one-cycle response strobe
- rsp_wr_rd  out  1  direction of completed command
- rsp_addr  out  ADDR_WIDTH  address of completed command
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes
- rsp_slverr  out  1  captured slave error
- busy  out  1  FIFO non-empty or FSM not IDLE
- err_count  out  16  saturating count of responses with rsp_slverr=1

## Operation
- FIFO: DEPTH entries of {wr_rd, addr, wdata}. Push on cmd_valid && cmd_ready. Pop only by FSM in IDLE. Read/write pointers wrap modulo DEPTH. Count width $clog2(DEPTH)+1.
- cmd_ready = (count != DEPTH), computed from registered count. When full, a push is refused even if a pop happens on the same edge.
- Push and pop on the same edge when not full: count unchanged, both take effect.
- FSM states: IDLE, DRIVE.
  - IDLE, FIFO non-empty: pop head, register apb_addr/apb_wdata/apb_wr_rd, hold_cnt = HOLD_CYCLES-1, go to DRIVE.
  - IDLE, FIFO empty: stay.
  - DRIVE, hold_cnt != 0: decrement.
  - DRIVE, hold_cnt == 0: sample apb_rdata and apb_slverr into the rsp_* registers, pulse rsp_valid, go to IDLE.
- apb_* outputs hold their last driven value between commands. They change only on a pop.
- rsp_rdata = apb_rdata for reads and 0 for writes. rsp_slverr is captured for both directions.
- rsp_wr_rd and rsp_addr are copies of the issued command. All rsp_* data fields hold until the next response.
- err_count increments on each rsp_valid with rsp_slverr=1 and saturates at 16'hFFFF.

## Timing
- Reset (asynchronous assert, synchronous to apb_clk on release):
  - All outputs are 0; cmd_ready = 1; FSM is IDLE.
  - FIFO is emptied; err_count = 0.
- Reset mid-command: the in-flight command and all queued commands are discarded. No rsp_valid is produced for them.
- Command pushed at edge E0 into an empty, idle issuer:
  - apb_* outputs update at E0+1.
  - They are held through edge E0+HOLD_CYCLES.
  - rsp_* are registered at edge E0+1+HOLD_CYCLES; rsp_valid is high for exactly that one cycle.
  - Default latency from accept to response: 4 cycles.
- Back-to-back commands: the next pop occurs at the edge after the response edge. Issue period = HOLD_CYCLES+1 cycles (4 by default).
- rsp_valid is never high on two consecutive cycles.
- busy is high from the edge after the first push until the response edge of the last queued command.

## Test plan
- Single write, then single read, to addr 3 with wdata 32'hDEADBEEF (defaults):
  - The write response has rsp_wr_rd=1, rsp_rdata=0, rsp_slverr=0.
  - The read rsp_valid arrives 4 cycles after its accept, with rsp_rdata=32'hDEADBEEF.
- Burst of 6 commands (writes to addr 0-5) offered back-to-back with cmd_valid held high:
  - cmd_ready drops after 5 accepts (4 queued + 1 popped), then re-asserts one per issue period.
  - 6 responses arrive in address order, spaced exactly 4 cycles apart.
- Pointer wrap: 10 alternating write/read pairs to addr 0-4 → all reads return the last written data, in order, with no lost or duplicated commands.
- Force apb_slverr=1 during the hold window of 3 commands → rsp_slverr=1 on each; err_count=3.
- Assert apb_resetn low 2 cycles into the DRIVE of the first of 3 queued commands:
  - All outputs go to 0 immediately; cmd_ready=1; busy=0.
  - No rsp_valid occurs after reset is released.
- Simultaneous push and pop with count=2 → count stays 2, cmd_ready stays 1, and the pushed command is issued third.

Source files
------------

// File: rtl/apb_cmd_issuer_if.sv
// Command, APB-master and response signals of apb_cmd_issuer.
// The master modport is the issuer; the slave modport is whatever sits around it.
interface apb_cmd_issuer_if #(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_wr_rd;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [DATA_WIDTH-1:0] cmd_wdata;

    logic [ADDR_WIDTH-1:0] apb_addr;
    logic [DATA_WIDTH-1:0] apb_wdata;
    logic                  apb_wr_rd;
    logic [DATA_WIDTH-1:0] apb_rdata;
    logic                  apb_slverr;

    logic                  rsp_valid;
    logic                  rsp_wr_rd;
    logic [ADDR_WIDTH-1:0] rsp_addr;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  rsp_slverr;

    modport master (
        input  cmd_valid, cmd_wr_rd, cmd_addr, cmd_wdata, apb_rdata, apb_slverr,
        output cmd_ready, apb_addr, apb_wdata, apb_wr_rd,
               rsp_valid, rsp_wr_rd, rsp_addr, rsp_rdata, rsp_slverr
    );

    modport slave (
        output cmd_valid, cmd_wr_rd, cmd_addr, cmd_wdata, apb_rdata, apb_slverr,
        input  cmd_ready, apb_addr, apb_wdata, apb_wr_rd,
               rsp_valid, rsp_wr_rd, rsp_addr, rsp_rdata, rsp_slverr
    );
endinterface

// File: rtl/apb_cmd_issuer.sv
// Buffers valid/ready commands in a small FIFO, holds each on the APB master
// inputs for HOLD_CYCLES cycles, then captures the result as a one-cycle response.
module apb_cmd_issuer #(
    parameter int unsigned ADDR_WIDTH  = 10,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned HOLD_CYCLES = 3
) (
    input  logic             apb_clk,
    input  logic             apb_resetn,
    apb_cmd_issuer_if.master bus,
    output logic             busy,
    output logic [15:0]      err_count
);
    localparam int unsigned PTR_W   = $clog2(DEPTH);
    localparam int unsigned CNT_W   = PTR_W + 1;
    localparam int unsigned HOLD_W  = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int unsigned ENTRY_W = 1 + ADDR_WIDTH + DATA_WIDTH;

    typedef enum logic {
        IDLE,
        DRIVE
    } state_t;

    state_t              state_q, state_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic                pop;
    logic                rsp_fire;

    logic [ENTRY_W-1:0]  fifo_mem [DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]    count_q;
    logic                ready;
    logic                push;
    logic                fifo_empty;

    logic                  head_wr_rd;
    logic [ADDR_WIDTH-1:0] head_addr;
    logic [DATA_WIDTH-1:0] head_wdata;

    logic                  apb_wr_rd_q;
    logic [ADDR_WIDTH-1:0] apb_addr_q;
    logic [DATA_WIDTH-1:0] apb_wdata_q;
    logic                  rsp_valid_q;
    logic                  rsp_wr_rd_q;
    logic [ADDR_WIDTH-1:0] rsp_addr_q;
    logic [DATA_WIDTH-1:0] rsp_rdata_q;
    logic                  rsp_slverr_q;
    logic [15:0]           err_count_q;

    // Ready comes from the registered count only, so a full FIFO refuses a push
    // even on the edge where the FSM pops.
    assign ready      = (count_q != CNT_W'(DEPTH));
    assign fifo_empty = (count_q == '0);
    assign push       = bus.cmd_valid && ready;
    assign {head_wr_rd, head_addr, head_wdata} = fifo_mem[rd_ptr_q];

    always_ff @(posedge apb_clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= {bus.cmd_wr_rd, bus.cmd_addr, bus.cmd_wdata};
        end
    end

    always_ff @(posedge apb_clk or negedge apb_resetn) begin
        if (!apb_resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge apb_clk or negedge apb_resetn) begin
        if (!apb_resetn) begin
            state_q <= IDLE;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        hold_d   = hold_q;
        pop      = 1'b0;
        rsp_fire = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    hold_d  = HOLD_W'(HOLD_CYCLES - 1);
                    state_d = DRIVE;
                end
            end
            DRIVE: begin
                if (hold_q != '0) begin
                    hold_d = hold_q - 1'b1;
                end else begin
                    rsp_fire = 1'b1;
                    state_d  = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge apb_clk or negedge apb_resetn) begin
        if (!apb_resetn) begin
            apb_wr_rd_q  <= 1'b0;
            apb_addr_q   <= '0;
            apb_wdata_q  <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_wr_rd_q  <= 1'b0;
            rsp_addr_q   <= '0;
            rsp_rdata_q  <= '0;
            rsp_slverr_q <= 1'b0;
            err_count_q  <= '0;
        end else begin
            rsp_valid_q <= rsp_fire;
            if (pop) begin
                apb_wr_rd_q <= head_wr_rd;
                apb_addr_q  <= head_addr;
                apb_wdata_q <= head_wdata;
            end
            if (rsp_fire) begin
                rsp_wr_rd_q  <= apb_wr_rd_q;
                rsp_addr_q   <= apb_addr_q;
                rsp_rdata_q  <= apb_wr_rd_q ? '0 : bus.apb_rdata;
                rsp_slverr_q <= bus.apb_slverr;
                if (bus.apb_slverr && (err_count_q != 16'hFFFF)) begin
                    err_count_q <= err_count_q + 1'b1;
                end
            end
        end
    end

    assign bus.cmd_ready  = ready;
    assign bus.apb_wr_rd  = apb_wr_rd_q;
    assign bus.apb_addr   = apb_addr_q;
    assign bus.apb_wdata  = apb_wdata_q;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_wr_rd  = rsp_wr_rd_q;
    assign bus.rsp_addr   = rsp_addr_q;
    assign bus.rsp_rdata  = rsp_rdata_q;
    assign bus.rsp_slverr = rsp_slverr_q;
    assign busy           = !fifo_empty || (state_q != IDLE);
    assign err_count      = err_count_q;
endmodule

// File: tb/tb_apb_cmd_issuer.sv
// Scoreboard bench for apb_cmd_issuer: a reference memory predicts each response
// and its arrival cycle at push time; a fake APB slave answers the issued commands.
`timescale 1ns/1ps
module tb_apb_cmd_issuer;
    localparam int unsigned AW   = 10;
    localparam int unsigned DW   = 32;
    localparam int unsigned HOLD = 3;
    localparam int unsigned LAT  = HOLD + 1;

    logic        apb_clk    = 1'b0;
    logic        apb_resetn = 1'b0;
    logic        busy;
    logic [15:0] err_count;

    apb_cmd_issuer_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) b ();

    apb_cmd_issuer #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .DEPTH      (4),
        .HOLD_CYCLES(HOLD)
    ) dut (
        .apb_clk   (apb_clk),
        .apb_resetn(apb_resetn),
        .bus       (b),
        .busy      (busy),
        .err_count (err_count)
    );

    always #5 apb_clk = ~apb_clk;

    typedef struct packed {
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] rdata;
        logic          slverr;
    } rsp_t;

    typedef struct packed {
        rsp_t        f;
        logic [31:0] cyc;
    } rec_t;

    rec_t          exp_q[$];
    rec_t          got_q[$];
    int unsigned   vectors     = 0;
    int unsigned   miscompares = 0;
    logic [31:0]   cyc         = 0;
    logic [31:0]   last_rsp    = 0;
    logic [31:0]   acc_cyc     = 0;
    logic [DW-1:0] ref_mem [1 << AW];
    logic [DW-1:0] slv_mem [1 << AW];
    int unsigned   b2b         = 0;
    logic          prev_rsp    = 1'b0;

    always @(posedge apb_clk) cyc <= cyc + 1;

    // Stand-in for the APB master plus slave: writes land while the command is held.
    always @(posedge apb_clk) begin
        if (!apb_resetn) begin
            for (int i = 0; i < (1 << AW); i++) slv_mem[i] <= '0;
        end else if (b.apb_wr_rd === 1'b1) begin
            slv_mem[b.apb_addr] <= b.apb_wdata;
        end
    end
    assign b.apb_rdata = slv_mem[b.apb_addr];

    always @(negedge apb_clk) begin
        rec_t r;
        if (b.rsp_valid === 1'b1) begin
            r.f.wr     = b.rsp_wr_rd;
            r.f.addr   = b.rsp_addr;
            r.f.rdata  = b.rsp_rdata;
            r.f.slverr = b.rsp_slverr;
            r.cyc      = cyc;
            got_q.push_back(r);
            if (prev_rsp) b2b++;
        end
        prev_rsp = (b.rsp_valid === 1'b1);
    end

    // Called on a falling edge; returns on the falling edge after the accepting edge.
    task automatic push_cmd(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        rec_t        e;
        bit          acc;
        int unsigned t;
        b.cmd_valid = 1'b1;
        b.cmd_wr_rd = wr;
        b.cmd_addr  = a;
        b.cmd_wdata = d;
        acc = 1'b0;
        t   = 0;
        while (!acc && t < 100) begin
            acc = (b.cmd_ready === 1'b1);
            @(negedge apb_clk);
            t++;
        end
        b.cmd_valid = 1'b0;
        if (!acc) begin
            vectors++;
            miscompares++;
            $display("FAIL push_timeout addr=%0d: cmd_ready stayed %b, required 1", a, b.cmd_ready);
        end else begin
            acc_cyc    = cyc;
            e.f.wr     = wr;
            e.f.addr   = a;
            e.f.rdata  = wr ? '0 : ref_mem[a];
            e.f.slverr = b.apb_slverr;
            e.cyc      = ((acc_cyc > last_rsp) ? acc_cyc + 1 : last_rsp + 1) + HOLD;
            last_rsp   = e.cyc;
            exp_q.push_back(e);
            if (wr) ref_mem[a] = d;
        end
    endtask

    task automatic get_rsp(output rec_t r, output bit ok);
        int unsigned t = 0;
        while (got_q.size() == 0 && t < 400) begin
            @(negedge apb_clk);
            t++;
        end
        ok = (got_q.size() != 0);
        if (ok) r = got_q.pop_front();
        else    r = '0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge apb_clk);
        vectors++;
        if ({b.apb_addr, b.apb_wdata, b.apb_wr_rd, b.rsp_valid, b.rsp_wr_rd, b.rsp_addr,
             b.rsp_rdata, b.rsp_slverr, busy, err_count} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: got apb_addr=%h rsp_valid=%b busy=%b err_count=%h, required all 0",
                     b.apb_addr, b.rsp_valid, busy, err_count);
        end
        vectors++;
        if (b.cmd_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_ready: got %b, required 1", b.cmd_ready);
        end
        apb_resetn = 1'b1;
        repeat (2) @(negedge apb_clk);
        vectors++;
        if ({b.cmd_ready, b.rsp_valid, busy, err_count} !== {1'b1, 1'b0, 1'b0, 16'h0}) begin
            miscompares++;
            $display("FAIL post_reset_idle: got ready=%b rsp_valid=%b busy=%b err=%h, required 1 0 0 0000",
                     b.cmd_ready, b.rsp_valid, busy, err_count);
        end
    endtask

    task automatic test_single();
        rec_t        g, e;
        bit          ok;
        logic [31:0] a0;
        push_cmd(1'b1, 10'd3, 32'hDEADBEEF);
        @(negedge apb_clk);
        vectors++;
        if ({b.apb_wr_rd, b.apb_addr, b.apb_wdata} !== {1'b1, 10'd3, 32'hDEADBEEF}) begin
            miscompares++;
            $display("FAIL apb_drive: got wr=%b addr=%0d wdata=%h, required 1 3 deadbeef",
                     b.apb_wr_rd, b.apb_addr, b.apb_wdata);
        end
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("FAIL busy_active: got %b, required 1", busy);
        end
        get_rsp(g, ok);
        e = exp_q.pop_front();
        vectors++;
        if (!ok || g.f !== e.f || g.f !== {1'b1, 10'd3, 32'h0, 1'b0}) begin
            miscompares++;
            $display("FAIL single_write_rsp: got %h, required %h", g.f, e.f);
        end
        push_cmd(1'b0, 10'd3, 32'h12345678);
        a0 = acc_cyc;
        get_rsp(g, ok);
        e = exp_q.pop_front();
        vectors++;
        if (!ok || g.f !== {1'b0, 10'd3, 32'hDEADBEEF, 1'b0}) begin
            miscompares++;
            $display("FAIL single_read_rsp: got %h, required %h", g.f, e.f);
        end
        vectors++;
        if (!ok || (g.cyc - a0) !== LAT) begin
            miscompares++;
            $display("FAIL single_read_latency: got %0d cycles, required %0d", g.cyc - a0, LAT);
        end
        repeat (2) @(negedge apb_clk);
        vectors++;
        if ({b.rsp_valid, b.rsp_addr, b.rsp_rdata, b.apb_addr, busy} !== {1'b0, 10'd3, 32'hDEADBEEF, 10'd3, 1'b0}) begin
            miscompares++;
            $display("FAIL single_hold: got rsp_valid=%b rsp_addr=%0d rsp_rdata=%h apb_addr=%0d busy=%b, required 0 3 deadbeef 3 0",
                     b.rsp_valid, b.rsp_addr, b.rsp_rdata, b.apb_addr, busy);
        end
    endtask

    task automatic test_burst();
        rec_t        g, e;
        bit          ok;
        logic [31:0] acc [6];
        logic [31:0] prev;
        for (int i = 0; i < 6; i++) begin
            push_cmd(1'b1, AW'(i), $urandom);
            acc[i] = acc_cyc;
            if (i == 4) begin
                vectors++;
                if (b.cmd_ready !== 1'b0) begin
                    miscompares++;
                    $display("FAIL burst_full: cmd_ready got %b after 5 accepts, required 0", b.cmd_ready);
                end
            end
        end
        vectors++;
        if (acc[4] - acc[0] !== 32'd4) begin
            miscompares++;
            $display("FAIL burst_accept5: got span %0d, required 4", acc[4] - acc[0]);
        end
        vectors++;
        if (acc[5] - acc[0] !== 32'd6) begin
            miscompares++;
            $display("FAIL burst_refill: got span %0d, required 6", acc[5] - acc[0]);
        end
        prev = 0;
        for (int i = 0; i < 6; i++) begin
            get_rsp(g, ok);
            e = exp_q.pop_front();
            vectors++;
            if (!ok || g.f !== e.f || g.cyc !== e.cyc) begin
                miscompares++;
                $display("FAIL burst_rsp[%0d]: got %h at cycle %0d, required %h at cycle %0d", i, g.f, g.cyc, e.f, e.cyc);
            end
            if (i > 0) begin
                vectors++;
                if (g.cyc - prev !== LAT) begin
                    miscompares++;
                    $display("FAIL burst_spacing[%0d]: got %0d, required %0d", i, g.cyc - prev, LAT);
                end
            end
            prev = g.cyc;
        end
        vectors++;
        if (b2b !== 0) begin
            miscompares++;
            $display("FAIL rsp_consecutive: got %0d back-to-back strobes, required 0", b2b);
        end
    endtask

    task automatic test_wrap();
        rec_t g, e;
        bit   ok;
        for (int i = 0; i < 10; i++) begin
            push_cmd(1'b1, AW'(i % 5), $urandom);
            push_cmd(1'b0, AW'(i % 5), $urandom);
        end
        for (int i = 0; i < 20; i++) begin
            get_rsp(g, ok);
            e = exp_q.pop_front();
            vectors++;
            if (!ok || g.f !== e.f || g.cyc !== e.cyc) begin
                miscompares++;
                $display("FAIL wrap_rsp[%0d]: got %h at cycle %0d, required %h at cycle %0d", i, g.f, g.cyc, e.f, e.cyc);
            end
        end
    endtask

    task automatic test_slverr();
        rec_t g, e;
        bit   ok;
        b.apb_slverr = 1'b1;
        push_cmd(1'b1, 10'd20, 32'hA5A5_0001);
        push_cmd(1'b0, 10'd20, 32'h0);
        push_cmd(1'b1, 10'd21, 32'hA5A5_0002);
        for (int i = 0; i < 3; i++) begin
            get_rsp(g, ok);
            e = exp_q.pop_front();
            vectors++;
            if (!ok || g.f !== e.f || g.f.slverr !== 1'b1) begin
                miscompares++;
                $display("FAIL slverr_rsp[%0d]: got %h, required %h", i, g.f, e.f);
            end
        end
        b.apb_slverr = 1'b0;
        vectors++;
        if (err_count !== 16'd3) begin
            miscompares++;
            $display("FAIL err_count: got %0d, required 3", err_count);
        end
    endtask

    task automatic test_push_pop();
        rec_t        g, e;
        bit          ok;
        logic [31:0] a0;
        push_cmd(1'b1, 10'd100, 32'h1111_0000);
        a0 = acc_cyc;
        push_cmd(1'b1, 10'd101, 32'h2222_0000);
        push_cmd(1'b1, 10'd102, 32'h3333_0000);
        repeat (2) @(negedge apb_clk);
        // Accepted on the same edge that pops the second command, with two queued.
        push_cmd(1'b0, 10'd102, 32'h0);
        vectors++;
        if ({acc_cyc - a0, b.cmd_ready} !== {32'd5, 1'b1}) begin
            miscompares++;
            $display("FAIL pushpop_accept: got offset %0d ready=%b, required 5 1", acc_cyc - a0, b.cmd_ready);
        end
        push_cmd(1'b1, 10'd103, 32'h4444_0000);
        push_cmd(1'b1, 10'd104, 32'h5555_0000);
        vectors++;
        if ({acc_cyc - a0, b.cmd_ready} !== {32'd7, 1'b0}) begin
            miscompares++;
            $display("FAIL pushpop_count: got offset %0d ready=%b, required 7 0", acc_cyc - a0, b.cmd_ready);
        end
        for (int i = 0; i < 6; i++) begin
            get_rsp(g, ok);
            e = exp_q.pop_front();
            vectors++;
            if (!ok || g.f !== e.f || g.cyc !== e.cyc) begin
                miscompares++;
                $display("FAIL pushpop_rsp[%0d]: got %h at cycle %0d, required %h at cycle %0d", i, g.f, g.cyc, e.f, e.cyc);
            end
        end
    endtask

    task automatic test_reset_mid();
        push_cmd(1'b0, 10'd1, 32'h0);
        push_cmd(1'b0, 10'd2, 32'h0);
        push_cmd(1'b0, 10'd3, 32'h0);
        @(negedge apb_clk);
        #2 apb_resetn = 1'b0;
        #1;
        vectors++;
        if ({b.apb_addr, b.apb_wdata, b.apb_wr_rd, b.rsp_valid, b.rsp_wr_rd, b.rsp_addr,
             b.rsp_rdata, b.rsp_slverr, busy, err_count} !== '0) begin
            miscompares++;
            $display("FAIL midreset_outputs: got apb_addr=%0d rsp_addr=%0d busy=%b err_count=%0d, required all 0",
                     b.apb_addr, b.rsp_addr, busy, err_count);
        end
        vectors++;
        if (b.cmd_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL midreset_ready: got %b, required 1", b.cmd_ready);
        end
        exp_q.delete();
        last_rsp = 0;
        repeat (2) @(negedge apb_clk);
        apb_resetn = 1'b1;
        repeat (20) @(negedge apb_clk);
        vectors++;
        if (got_q.size() !== 0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL midreset_discard: got %0d responses busy=%b, required 0 0", got_q.size(), busy);
        end
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) ref_mem[i] = '0;
        b.cmd_valid  = 1'b0;
        b.cmd_wr_rd  = 1'b0;
        b.cmd_addr   = '0;
        b.cmd_wdata  = '0;
        b.apb_slverr = 1'b0;
        test_reset();
        test_single();
        test_burst();
        test_wrap();
        test_slverr();
        test_push_pop();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
        $fatal(1, "watchdog expired");
    end
endmodule
